// File: rtl/trap_ctrl_pkg.sv
// ============================================================================
// Module  : trap_ctrl_pkg
// Brief   : Shared constants for the machine-mode trap sequencer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package trap_ctrl_pkg;

    // CSR addresses touched or referenced by the trap sequencer
    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MIE     = 12'h304;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MIP     = 12'h344;

    // mstatus bit positions
    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    // Interrupt cause codes (also the mie/mip bit positions)
    localparam logic [3:0] IRQ_CODE_MSI = 4'd3;
    localparam logic [3:0] IRQ_CODE_MTI = 4'd7;
    localparam logic [3:0] IRQ_CODE_MEI = 4'd11;

    // Synchronous exception codes
    localparam logic [3:0] EXC_INSN_MISALIGNED = 4'd0;
    localparam logic [3:0] EXC_INSN_FAULT      = 4'd1;
    localparam logic [3:0] EXC_ILLEGAL_INSN    = 4'd2;
    localparam logic [3:0] EXC_BREAKPOINT      = 4'd3;
    localparam logic [3:0] EXC_LOAD_MISALIGNED = 4'd4;
    localparam logic [3:0] EXC_LOAD_FAULT      = 4'd5;
    localparam logic [3:0] EXC_STORE_MISALIGN  = 4'd6;
    localparam logic [3:0] EXC_STORE_FAULT     = 4'd7;
    localparam logic [3:0] EXC_ECALL_M         = 4'd11;

    // Trap sequencer state encoding
    localparam int TRAP_STATE_WIDTH = 3;
    localparam logic [TRAP_STATE_WIDTH-1:0] ST_IDLE         = 3'd0;
    localparam logic [TRAP_STATE_WIDTH-1:0] ST_WR_MEPC      = 3'd1;
    localparam logic [TRAP_STATE_WIDTH-1:0] ST_WR_MCAUSE    = 3'd2;
    localparam logic [TRAP_STATE_WIDTH-1:0] ST_WR_MSTATUS   = 3'd3;
    localparam logic [TRAP_STATE_WIDTH-1:0] ST_MRET_MSTATUS = 3'd4;
    localparam logic [TRAP_STATE_WIDTH-1:0] ST_REDIRECT     = 3'd5;

endpackage : trap_ctrl_pkg

`default_nettype wire

// File: rtl/trap_ctrl_if.sv
// ============================================================================
// Module  : trap_ctrl_if
// Brief   : Commit-point, CSR-snoop and trap-control signals of trap_ctrl.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface trap_ctrl_if #(
    parameter int XLEN       = 32,
    parameter int CSR_ADDR_W = 12
);
    logic                  commit_valid;
    logic [XLEN-1:0]       commit_pc;
    logic [XLEN-1:0]       commit_pc4;
    logic                  commit_exc;
    logic [3:0]            commit_exc_code;
    logic                  commit_mret;
    logic                  irq_msi;
    logic                  irq_mti;
    logic                  irq_mei;
    logic [XLEN-1:0]       mstatus_q;
    logic [XLEN-1:0]       mie_q;
    logic [XLEN-1:0]       mtvec_q;
    logic [XLEN-1:0]       mepc_q;

    logic                  flush;
    logic                  commit_kill;
    logic                  csr_we;
    logic [CSR_ADDR_W-1:0] csr_waddr;
    logic [XLEN-1:0]       csr_wdata;
    logic                  redirect_valid;
    logic [XLEN-1:0]       redirect_pc;
    logic                  busy;

    // Pipeline / CSR-file side
    modport master (
        output commit_valid, commit_pc, commit_pc4, commit_exc, commit_exc_code,
               commit_mret, irq_msi, irq_mti, irq_mei,
               mstatus_q, mie_q, mtvec_q, mepc_q,
        input  flush, commit_kill, csr_we, csr_waddr, csr_wdata,
               redirect_valid, redirect_pc, busy
    );

    // Trap sequencer side
    modport slave (
        input  commit_valid, commit_pc, commit_pc4, commit_exc, commit_exc_code,
               commit_mret, irq_msi, irq_mti, irq_mei,
               mstatus_q, mie_q, mtvec_q, mepc_q,
        output flush, commit_kill, csr_we, csr_waddr, csr_wdata,
               redirect_valid, redirect_pc, busy
    );

endinterface : trap_ctrl_if

`default_nettype wire

// File: rtl/trap_ctrl_irq_prio_enc.sv
// ============================================================================
// Module  : irq_prio_enc
// Brief   : Enabled-interrupt priority encoder (MEI > MSI > MTI), combinational.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module irq_prio_enc
    import trap_ctrl_pkg::*;
(
    input  wire logic       msi_i,
    input  wire logic       mti_i,
    input  wire logic       mei_i,
    input  wire logic       msie_i,
    input  wire logic       mtie_i,
    input  wire logic       meie_i,
    input  wire logic       gie_i,
    output logic            take_o,
    output logic [3:0]      code_o
);

    logic w_msi;
    logic w_mti;
    logic w_mei;

    assign w_msi = msi_i & msie_i;
    assign w_mti = mti_i & mtie_i;
    assign w_mei = mei_i & meie_i;

    always_comb begin
        take_o = gie_i & (w_msi | w_mti | w_mei);
        code_o = 4'd0;
        if (w_mei)      code_o = IRQ_CODE_MEI;
        else if (w_msi) code_o = IRQ_CODE_MSI;
        else if (w_mti) code_o = IRQ_CODE_MTI;
    end

endmodule : irq_prio_enc

`default_nettype wire

// File: rtl/trap_ctrl.sv
// ============================================================================
// Module  : trap_ctrl
// Brief   : Machine-mode trap/MRET sequencer at the WB commit point.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module trap_ctrl
    import trap_ctrl_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int CSR_ADDR_W  = 12,
    parameter bit VECTORED_EN = 1'b1
) (
    input  wire logic  clk,
    input  wire logic  rst,
    trap_ctrl_if.slave bus
);

    logic [TRAP_STATE_WIDTH-1:0] state_q, state_d;
    logic [XLEN-1:0]             epc_q, epc_d;
    logic [XLEN-1:0]             cause_q, cause_d;
    logic                        is_irq_q, is_irq_d;
    logic                        mret_q, mret_d;

    logic                        w_irq_take;
    logic [3:0]                  w_irq_code;
    logic                        w_take;
    logic                        w_busy;
    logic [XLEN-1:0]             w_vec_off;
    logic [XLEN-1:0]             w_ms_trap;
    logic [XLEN-1:0]             w_ms_mret;
    logic                        w_unused;

    logic                        w_flush;
    logic                        w_kill;
    logic                        w_csr_we;
    logic [CSR_ADDR_W-1:0]       w_csr_waddr;
    logic [XLEN-1:0]             w_csr_wdata;
    logic                        w_redir_valid;
    logic [XLEN-1:0]             w_redir_pc;

    irq_prio_enc u_prio (
        .msi_i  (bus.irq_msi),
        .mti_i  (bus.irq_mti),
        .mei_i  (bus.irq_mei),
        .msie_i (bus.mie_q[IRQ_CODE_MSI]),
        .mtie_i (bus.mie_q[IRQ_CODE_MTI]),
        .meie_i (bus.mie_q[IRQ_CODE_MEI]),
        .gie_i  (bus.mstatus_q[MSTATUS_MIE]),
        .take_o (w_irq_take),
        .code_o (w_irq_code)
    );

    assign w_busy = (state_q != ST_IDLE);
    assign w_take = ~rst & ~w_busy & bus.commit_valid &
                    (bus.commit_exc | bus.commit_mret | w_irq_take);

    // Vector offset only applies to interrupts with mtvec.MODE == 1
    generate
        if (VECTORED_EN) begin : g_vec
            assign w_vec_off = (is_irq_q && bus.mtvec_q[1:0] == 2'b01)
                             ? {{(XLEN-6){1'b0}}, cause_q[3:0], 2'b00}
                             : '0;
        end else begin : g_direct
            assign w_vec_off = '0;
        end
    endgenerate

    always_comb begin
        w_ms_trap                  = bus.mstatus_q;
        w_ms_trap[MSTATUS_MPIE]    = bus.mstatus_q[MSTATUS_MIE];
        w_ms_trap[MSTATUS_MIE]     = 1'b0;
        w_ms_trap[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;

        w_ms_mret                  = bus.mstatus_q;
        w_ms_mret[MSTATUS_MIE]     = bus.mstatus_q[MSTATUS_MPIE];
        w_ms_mret[MSTATUS_MPIE]    = 1'b1;
        w_ms_mret[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    end

    // State and captured-register process
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            epc_q    <= '0;
            cause_q  <= '0;
            is_irq_q <= 1'b0;
            mret_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            epc_q    <= epc_d;
            cause_q  <= cause_d;
            is_irq_q <= is_irq_d;
            mret_q   <= mret_d;
        end
    end

    // Next-state process
    always_comb begin
        state_d  = state_q;
        epc_d    = epc_q;
        cause_d  = cause_q;
        is_irq_d = is_irq_q;
        mret_d   = mret_q;
        case (state_q)
            ST_IDLE: begin
                if (w_take) begin
                    if (bus.commit_exc) begin
                        state_d  = ST_WR_MEPC;
                        epc_d    = bus.commit_pc;
                        cause_d  = {1'b0, {(XLEN-5){1'b0}}, bus.commit_exc_code};
                        is_irq_d = 1'b0;
                        mret_d   = 1'b0;
                    end else if (bus.commit_mret) begin
                        state_d  = ST_MRET_MSTATUS;
                        is_irq_d = 1'b0;
                        mret_d   = 1'b1;
                    end else begin
                        state_d  = ST_WR_MEPC;
                        epc_d    = bus.commit_pc4;
                        cause_d  = {1'b1, {(XLEN-5){1'b0}}, w_irq_code};
                        is_irq_d = 1'b1;
                        mret_d   = 1'b0;
                    end
                end
            end
            ST_WR_MEPC:      state_d = ST_WR_MCAUSE;
            ST_WR_MCAUSE:    state_d = ST_WR_MSTATUS;
            ST_WR_MSTATUS:   state_d = ST_REDIRECT;
            ST_MRET_MSTATUS: state_d = ST_REDIRECT;
            ST_REDIRECT:     state_d = ST_IDLE;
            default:         state_d = ST_IDLE;
        endcase
    end

    // Output process: everything is suppressed while reset is asserted
    always_comb begin
        w_flush       = 1'b0;
        w_kill        = 1'b0;
        w_csr_we      = 1'b0;
        w_csr_waddr   = '0;
        w_csr_wdata   = '0;
        w_redir_valid = 1'b0;
        w_redir_pc    = '0;
        if (!rst) begin
            w_flush = w_take | w_busy;
            w_kill  = w_take & bus.commit_exc;
            case (state_q)
                ST_WR_MEPC: begin
                    w_csr_we    = 1'b1;
                    w_csr_waddr = CSR_ADDR_W'(CSR_MEPC);
                    w_csr_wdata = epc_q;
                end
                ST_WR_MCAUSE: begin
                    w_csr_we    = 1'b1;
                    w_csr_waddr = CSR_ADDR_W'(CSR_MCAUSE);
                    w_csr_wdata = cause_q;
                end
                ST_WR_MSTATUS: begin
                    w_csr_we    = 1'b1;
                    w_csr_waddr = CSR_ADDR_W'(CSR_MSTATUS);
                    w_csr_wdata = w_ms_trap;
                end
                ST_MRET_MSTATUS: begin
                    w_csr_we    = 1'b1;
                    w_csr_waddr = CSR_ADDR_W'(CSR_MSTATUS);
                    w_csr_wdata = w_ms_mret;
                end
                ST_REDIRECT: begin
                    w_redir_valid = 1'b1;
                    w_redir_pc    = mret_q ? {bus.mepc_q[XLEN-1:2], 2'b00}
                                           : {bus.mtvec_q[XLEN-1:2], 2'b00} + w_vec_off;
                end
                default: ;
            endcase
        end
    end

    assign bus.flush          = w_flush;
    assign bus.commit_kill    = w_kill;
    assign bus.csr_we         = w_csr_we;
    assign bus.csr_waddr      = w_csr_waddr;
    assign bus.csr_wdata      = w_csr_wdata;
    assign bus.redirect_valid = w_redir_valid;
    assign bus.redirect_pc    = w_redir_pc;
    assign bus.busy           = ~rst & w_busy;

    // Only the three standard interrupt-enable bits and aligned vector bases are consumed
    assign w_unused = ^{bus.mie_q, bus.mepc_q[1:0], bus.mtvec_q[1:0], cause_q};

endmodule : trap_ctrl

`default_nettype wire

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
- Machine-mode trap sequencer at the commit (WB) point of the 5-stage RV32I pipeline.
- On a committing exception, MRET or enabled interrupt, it flushes all stages. It then writes mepc, mcause and mstatus one at a time through the CSR file's single write port, and redirects fetch to the mtvec target or to mepc.
- Sits beside the existing pipeline controller; its flush ORs into the existing branch-cancel path.

Parameters:
- XLEN, 32, datapath width.
- CSR_ADDR_W, 12, CSR address width.
- VECTORED_EN, 1, when 1 honour mtvec.MODE=1 for interrupts; when 0 always use direct mode.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- commit_valid  in  1  WB holds a valid instruction this cycle
- commit_pc  in  32  pc of the committing instruction
- commit_pc4  in  32  pc+4 of the committing instruction
- commit_exc  in  1  committing instruction raised a synchronous exception
- commit_exc_code  in  4  exception code (e.g. 2 = illegal instruction, 11 = ecall)
- commit_mret  in  1  committing instruction is MRET
- irq_msi, irq_mti, irq_mei  in  1 each  pending software, timer and external interrupt lines
- mstatus_q, mie_q, mtvec_q, mepc_q  in  32 each  live CSR values from the CSR file
- flush  out  1  cancels valid bits in IF, ID, EX and MEM
- commit_kill  out  1  suppresses the rf/CSR write of the current WB instruction
- csr_we  out  1  trap CSR write enable, which has priority over the ID-path CSR write
- csr_waddr  out  12  trap CSR write address
- csr_wdata  out  32  trap CSR write data
- redirect_valid  out  1  one-cycle pulse; load PC with redirect_pc
- redirect_pc  out  32  new fetch PC
- busy  out  1  state is not IDLE

Behaviour:
- States: IDLE, WR_MEPC, WR_MCAUSE, WR_MSTATUS, MRET_MSTATUS, REDIRECT.
- Event priority in IDLE when commit_valid=1:
  - commit_exc first, then commit_mret, then interrupt.
  - An interrupt requires mstatus_q[3] (MIE) and at least one pending line with its mie_q bit set.
  - Among interrupts: MEI (code 11), then MSI (code 3), then MTI (code 7).
  - take = any event above, evaluated combinationally in IDLE only and masked by rst.
- Cycle T (take): flush=1.
  - commit_kill=1 for an exception only.
  - An MRET or interrupted instruction completes normally.
  - Captured registers, updated at the edge:
    - epc = commit_pc for an exception, commit_pc4 for an interrupt.
    - cause = {1'b0, 27'b0, code} for an exception, {1'b1, 27'b0, code} for an interrupt.
    - is_irq.
- Exception/interrupt path:
  - T+1 WR_MEPC: csr_we=1, addr 0x341, data epc.
  - T+2 WR_MCAUSE: csr_we=1, addr 0x342, data cause.
  - T+3 WR_MSTATUS: csr_we=1, addr 0x300. Data is mstatus_q with MPIE[7]=MIE[3], MIE[3]=0, MPP[12:11]=2'b11; all other bits unchanged.
  - T+4 REDIRECT: redirect_valid=1.
    - redirect_pc = {mtvec_q[31:2], 2'b00}.
    - If VECTORED_EN, is_irq and mtvec_q[1:0]=01: add 4*code.
  - T+5 IDLE.
- MRET path:
  - T+1 MRET_MSTATUS: csr_we=1, addr 0x300. Data is mstatus_q with MIE[3]=MPIE[7], MPIE[7]=1, MPP=2'b11.
  - T+2 REDIRECT: redirect_pc = {mepc_q[31:2], 2'b00}.
  - T+3 IDLE.
- flush = take OR busy, so it is held through REDIRECT inclusive. Fetch resumes at the edge ending REDIRECT.
- Outputs while not IDLE are decoded from the state and captured registers only; there are no combinational paths from commit_* to csr_*.
- Events while busy are ignored: flush guarantees commit_valid is 0 from T+1. Interrupt lines stay pending and are re-evaluated after IDLE.
- MRET and an interrupt in the same cycle: MRET is taken; the interrupt is taken on a later commit if still enabled.
- Reset values, including reset asserted mid-sequence: state=IDLE and all captured registers 0.
  - All outputs 0: flush, commit_kill, csr_we, redirect_valid, busy, csr_waddr, csr_wdata, redirect_pc.
  - No partial CSR write completes after reset.

Decomposition:
- Shared defines header additions:
  - CSR addresses 0x300, 0x304, 0x305, 0x341, 0x342, 0x344.
  - mstatus bit positions MIE=3, MPIE=7, MPP=12:11.
  - Interrupt codes 3, 7, 11.
  - TRAP_STATE_WIDTH = 3 and the state encodings.
  - Exception codes.
- Sub-module irq_prio_enc: pending & enable & MIE to {irq_take, code[3:0]}, purely combinational.

Test Plan:
- Illegal-instruction exception: commit_exc=1, code=2, pc=0x100, mtvec=0x200.
  - T: flush=1, kill=1.
  - Writes in order: mepc=0x100, mcause=0x2, mstatus MIE 1->0 with MPIE=1.
  - T+4: redirect 0x200, busy falls after.
- Vectored timer interrupt: mtvec=0x201, MIE=1, mie[7]=1, irq_mti=1, commit pc4=0x44.
  - mepc=0x44, mcause=0x80000007.
  - Redirect 0x21C, no kill.
- MRET: mstatus MPIE=1, MIE=0, mepc=0x104.
  - One write to 0x300 with MIE=1, MPIE=1.
  - Redirect 0x104 at T+2.
- Priority: commit_exc, commit_mret and irq_mei all high in one cycle.
  - Exception path taken, mcause = exception code.
  - Repeat with MIE=0 and only irq_mei: no take.
- Reset at T+2 of the exception sequence: next cycle state IDLE, csr_we=0, no redirect, busy=0.
  - A fresh exception afterwards runs the full sequence.
- Event while busy: pulse commit_valid and commit_exc at T+2 of an interrupt sequence → ignored, exactly one mcause write.
